// File: rtl/multi_queue.sv
// Multi-channel queue: NUM_CH independent FIFOs sharing one RAM.
// Each command runs IDLE -> EXEC -> DONE, so done rises two cycles after the strobe.
module multi_queue #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_CH     = 4,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       active,
    input  logic [1:0]                 cmd,
    input  logic [CH_W-1:0]            ch_sel,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic                       busy,
    output logic                       done,
    output logic                       signal_underflow,
    output logic                       signal_overflow,
    output logic [CH_W+ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [ADDR_WIDTH:0]        count_out,
    output logic [NUM_CH-1:0]          empty_flags,
    output logic [NUM_CH-1:0]          full_flags
);

    localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;
    typedef enum logic [1:0] {CmdAdd = 2'b00, CmdRemove = 2'b01, CmdPeek = 2'b10,
                              CmdClear = 2'b11} cmd_e;

    state_e state_q, state_d;
    cmd_e   cmd_q;
    logic [CH_W-1:0]       ch_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ovf_q, unf_q;

    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] head_q, tail_q;
    logic [NUM_CH-1:0][ADDR_WIDTH:0]   count_q;

    // Shared storage; channel c owns the block {c, pointer}.
    logic [DATA_WIDTH-1:0] mem [NUM_CH*DEPTH];

    logic [ADDR_WIDTH-1:0] cur_head, cur_tail, head_nx, tail_nx;
    logic [ADDR_WIDTH:0]   cur_count, count_nx;
    logic                  do_write, do_read, ovf_d, unf_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next state; active is only looked at in IDLE so strobes during a command are dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (active) state_d = StExec;
            StExec:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Capture the command on the IDLE->EXEC edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= CmdAdd;
            ch_q   <= '0;
            data_q <= '0;
        end else if (state_q == StIdle && active) begin
            cmd_q  <= cmd_e'(cmd);
            ch_q   <= ch_sel;
            data_q <= data_in;
        end
    end

    // Decode the latched command against the selected channel's pointers.
    always_comb begin
        cur_head  = head_q[ch_q];
        cur_tail  = tail_q[ch_q];
        cur_count = count_q[ch_q];
        head_nx   = cur_head;
        tail_nx   = cur_tail;
        count_nx  = cur_count;
        do_write  = 1'b0;
        do_read   = 1'b0;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        unique case (cmd_q)
            CmdAdd: begin
                if (cur_count == DepthCnt) begin
                    ovf_d = 1'b1;
                end else begin
                    do_write = 1'b1;
                    tail_nx  = cur_tail + ADDR_WIDTH'(1);
                    count_nx = cur_count + (ADDR_WIDTH + 1)'(1);
                end
            end
            CmdRemove: begin
                if (cur_count == '0) begin
                    unf_d = 1'b1;
                end else begin
                    do_read  = 1'b1;
                    head_nx  = cur_head + ADDR_WIDTH'(1);
                    count_nx = cur_count - (ADDR_WIDTH + 1)'(1);
                end
            end
            CmdPeek: begin
                if (cur_count == '0) unf_d = 1'b1;
                else                 do_read = 1'b1;
            end
            CmdClear: begin
                head_nx  = '0;
                tail_nx  = '0;
                count_nx = '0;
            end
            default: ;
        endcase
    end

    // Commit pointer/count updates and result registers at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            addr_out  <= '0;
            data_out  <= '0;
            count_out <= '0;
        end else if (state_q == StExec) begin
            head_q[ch_q]  <= head_nx;
            tail_q[ch_q]  <= tail_nx;
            count_q[ch_q] <= count_nx;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
            count_out     <= count_nx;
            if (do_write) addr_out <= {ch_q, cur_tail};
            if (do_read) begin
                addr_out <= {ch_q, cur_head};
                data_out <= mem[{ch_q, cur_head}];
            end
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (state_q == StExec && do_write) mem[{ch_q, cur_tail}] <= data_q;
    end

    // Live per-channel status from the registered counts.
    always_comb begin
        empty_flags = '0;
        full_flags  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            empty_flags[i] = (count_q[i] == '0);
            full_flags[i]  = (count_q[i] == DepthCnt);
        end
    end

    assign busy             = (state_q != StIdle);
    assign done             = (state_q == StDone);
    assign signal_overflow  = (state_q == StDone) && ovf_q;
    assign signal_underflow = (state_q == StDone) && unf_q;

endmodule

// File: tb/tb_multi_queue.sv
// Directed bench for multi_queue: a vector table for single commands plus
// hand-written sequences for fill/overflow, wrap-around and mid-command reset.
module tb_multi_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       active;
    logic [1:0] cmd;
    logic [1:0] ch_sel;
    logic [5:0] data_in;
    logic       busy, done, signal_underflow, signal_overflow;
    logic [5:0] addr_out;
    logic [5:0] data_out;
    logic [4:0] count_out;
    logic [3:0] empty_flags, full_flags;

    int n_cmp  = 0;
    int n_fail = 0;

    logic       cap_ovf, cap_unf;
    logic [5:0] cap_addr, cap_dout;
    logic [4:0] cap_cnt;
    logic [3:0] cap_empty, cap_full;

    multi_queue dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .active           (active),
        .cmd              (cmd),
        .ch_sel           (ch_sel),
        .data_in          (data_in),
        .busy             (busy),
        .done             (done),
        .signal_underflow (signal_underflow),
        .signal_overflow  (signal_overflow),
        .addr_out         (addr_out),
        .data_out         (data_out),
        .count_out        (count_out),
        .empty_flags      (empty_flags),
        .full_flags       (full_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish, required finish within 1 ms");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Issue one command and check the IDLE->EXEC->DONE->IDLE timing; results captured in DONE.
    task automatic run_cmd(input string tag, input logic [1:0] c, input logic [1:0] ch,
                           input logic [5:0] d, input bit hold);
        @(negedge clk);
        active = 1'b1; cmd = c; ch_sel = ch; data_in = d;
        @(posedge clk); #1;
        if (!hold) active = 1'b0;
        check({tag, " exec busy"}, 32'(busy), 1);
        check({tag, " exec done"}, 32'(done), 0);
        @(posedge clk); #1;
        check({tag, " done"}, 32'(done), 1);
        check({tag, " done busy"}, 32'(busy), 1);
        cap_ovf = signal_overflow;  cap_unf = signal_underflow;
        cap_addr = addr_out;        cap_dout = data_out;
        cap_cnt = count_out;        cap_empty = empty_flags;  cap_full = full_flags;
        @(posedge clk); #1;
        active = 1'b0;
        check({tag, " idle done"}, 32'(done), 0);
        check({tag, " idle busy"}, 32'(busy), 0);
        check({tag, " idle ovf"}, 32'(signal_overflow), 0);
        check({tag, " idle unf"}, 32'(signal_underflow), 0);
    endtask

    task automatic expect_op(input string tag, input logic ovf, input logic unf,
                             input logic [5:0] addr, input logic [5:0] dout,
                             input logic [4:0] cnt, input logic [3:0] emp, input logic [3:0] ful);
        check({tag, " ovf"}, 32'(cap_ovf), 32'(ovf));
        check({tag, " unf"}, 32'(cap_unf), 32'(unf));
        check({tag, " addr"}, 32'(cap_addr), 32'(addr));
        check({tag, " data"}, 32'(cap_dout), 32'(dout));
        check({tag, " count"}, 32'(cap_cnt), 32'(cnt));
        check({tag, " empty"}, 32'(cap_empty), 32'(emp));
        check({tag, " full"}, 32'(cap_full), 32'(ful));
    endtask

    typedef struct {
        logic [1:0] cmd;
        logic [1:0] ch;
        logic [5:0] din;
        bit         hold;
        logic       ovf;
        logic       unf;
        logic [5:0] addr;
        logic [5:0] dout;
        logic [4:0] cnt;
        logic [3:0] emp;
        logic [3:0] ful;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // cmd  ch  din   hold ovf unf addr   dout   cnt emp      ful
        vecs[0]  = '{2'b01, 2'd0, 6'h00, 0, 0, 1, 6'h00, 6'h00, 5'd0, 4'b1111, 4'b0000};
        vecs[1]  = '{2'b00, 2'd2, 6'h15, 1, 0, 0, 6'h20, 6'h00, 5'd1, 4'b1011, 4'b0000};
        vecs[2]  = '{2'b01, 2'd2, 6'h00, 0, 0, 0, 6'h20, 6'h15, 5'd0, 4'b1111, 4'b0000};
        vecs[3]  = '{2'b00, 2'd1, 6'h0A, 0, 0, 0, 6'h10, 6'h15, 5'd1, 4'b1101, 4'b0000};
        vecs[4]  = '{2'b10, 2'd1, 6'h00, 0, 0, 0, 6'h10, 6'h0A, 5'd1, 4'b1101, 4'b0000};
        vecs[5]  = '{2'b10, 2'd1, 6'h00, 0, 0, 0, 6'h10, 6'h0A, 5'd1, 4'b1101, 4'b0000};
        vecs[6]  = '{2'b00, 2'd2, 6'h07, 0, 0, 0, 6'h21, 6'h0A, 5'd1, 4'b1001, 4'b0000};
        vecs[7]  = '{2'b11, 2'd1, 6'h00, 0, 0, 0, 6'h21, 6'h0A, 5'd0, 4'b1011, 4'b0000};
        vecs[8]  = '{2'b10, 2'd2, 6'h00, 0, 0, 0, 6'h21, 6'h07, 5'd1, 4'b1011, 4'b0000};
        vecs[9]  = '{2'b01, 2'd2, 6'h00, 0, 0, 0, 6'h21, 6'h07, 5'd0, 4'b1111, 4'b0000};
        vecs[10] = '{2'b10, 2'd1, 6'h00, 0, 0, 1, 6'h21, 6'h07, 5'd0, 4'b1111, 4'b0000};

        rst_n = 1'b0; active = 1'b0; cmd = 2'b00; ch_sel = 2'd0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst ovf", 32'(signal_overflow), 0);
        check("rst unf", 32'(signal_underflow), 0);
        check("rst addr", 32'(addr_out), 0);
        check("rst data", 32'(data_out), 0);
        check("rst count", 32'(count_out), 0);
        check("rst empty", 32'(empty_flags), 32'hF);
        check("rst full", 32'(full_flags), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-command vectors: underflow, add/remove, peek twice, clear, hold-active.
        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_cmd(tag, vecs[i].cmd, vecs[i].ch, vecs[i].din, vecs[i].hold);
            expect_op(tag, vecs[i].ovf, vecs[i].unf, vecs[i].addr, vecs[i].dout,
                      vecs[i].cnt, vecs[i].emp, vecs[i].ful);
        end

        // Fill ch1, overflow once, then drain to show contents survived.
        for (int i = 0; i < 16; i++) begin
            run_cmd($sformatf("fill1_%0d", i), 2'b00, 2'd1, 6'(8'h20 + i), 0);
            expect_op($sformatf("fill1_%0d", i), 0, 0, 6'(8'h10 + i), 6'h07, 5'(i + 1),
                      4'b1101, (i == 15) ? 4'b0010 : 4'b0000);
        end
        run_cmd("ovf1", 2'b00, 2'd1, 6'h3E, 0);
        expect_op("ovf1", 1, 0, 6'h1F, 6'h07, 5'd16, 4'b1101, 4'b0010);
        for (int k = 0; k < 16; k++) begin
            run_cmd($sformatf("drain1_%0d", k), 2'b01, 2'd1, 6'h00, 0);
            expect_op($sformatf("drain1_%0d", k), 0, 0, 6'(8'h10 + k), 6'(8'h20 + k),
                      5'(15 - k), (k == 15) ? 4'b1111 : 4'b1101, 4'b0000);
        end

        // Wrap-around on ch3: fill, remove 4, add 4 into the freed low slots, drain.
        for (int i = 0; i < 16; i++) begin
            run_cmd($sformatf("fill3_%0d", i), 2'b00, 2'd3, 6'(i), 0);
            expect_op($sformatf("fill3_%0d", i), 0, 0, 6'(8'h30 + i), 6'h2F, 5'(i + 1),
                      4'b0111, (i == 15) ? 4'b1000 : 4'b0000);
        end
        for (int k = 0; k < 4; k++) begin
            run_cmd($sformatf("rm3_%0d", k), 2'b01, 2'd3, 6'h00, 0);
            expect_op($sformatf("rm3_%0d", k), 0, 0, 6'(8'h30 + k), 6'(k), 5'(15 - k),
                      4'b0111, 4'b0000);
        end
        for (int j = 0; j < 4; j++) begin
            run_cmd($sformatf("wrap3_%0d", j), 2'b00, 2'd3, 6'(8'h3C + j), 0);
            expect_op($sformatf("wrap3_%0d", j), 0, 0, 6'(8'h30 + j), 6'h03, 5'(13 + j),
                      4'b0111, (j == 3) ? 4'b1000 : 4'b0000);
        end
        for (int m = 0; m < 16; m++) begin
            logic [5:0] ea, ed;
            ea = (m < 12) ? 6'(8'h34 + m) : 6'(8'h30 + m - 12);
            ed = (m < 12) ? 6'(4 + m) : 6'(8'h3C + m - 12);
            run_cmd($sformatf("drain3_%0d", m), 2'b01, 2'd3, 6'h00, 0);
            expect_op($sformatf("drain3_%0d", m), 0, 0, ea, ed, 5'(15 - m),
                      (m == 15) ? 4'b1111 : 4'b0111, 4'b0000);
        end

        // Reset asserted while an add to ch0 sits in EXEC.
        run_cmd("pre_rst", 2'b00, 2'd2, 6'h05, 0);
        expect_op("pre_rst", 0, 0, 6'h22, 6'h3F, 5'd1, 4'b1011, 4'b0000);
        @(negedge clk);
        active = 1'b1; cmd = 2'b00; ch_sel = 2'd0; data_in = 6'h2A;
        @(posedge clk); #1;
        active = 1'b0;
        check("mid exec busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid rst busy", 32'(busy), 0);
        check("mid rst done", 32'(done), 0);
        check("mid rst empty", 32'(empty_flags), 32'hF);
        check("mid rst full", 32'(full_flags), 0);
        check("mid rst count", 32'(count_out), 0);
        check("mid rst addr", 32'(addr_out), 0);
        check("mid rst data", 32'(data_out), 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("mid rst no done %0d", c), 32'(done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd("post_rst ch2", 2'b10, 2'd2, 6'h00, 0);
        expect_op("post_rst ch2", 0, 1, 6'h00, 6'h00, 5'd0, 4'b1111, 4'b0000);
        run_cmd("post_rst ch0", 2'b01, 2'd0, 6'h00, 0);
        expect_op("post_rst ch0", 0, 1, 6'h00, 6'h00, 5'd0, 4'b1111, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_queue.md
MULTI_QUEUE -- requirements
Module: multi_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 6, entry width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, 4, per-channel address width; DEPTH = 2**ADDR_WIDTH entries per channel.
REQ-003 SHALL have parameter NUM_CH, 4, number of independent queues; power of two, >=2; CH_W = log2(NUM_CH).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port active  input  1  command strobe; sampled only in IDLE.
REQ-007 SHALL have port cmd  input  2  00 add, 01 remove, 10 peek, 11 clear.
REQ-008 SHALL have port ch_sel  input  CH_W  target channel.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  entry to enqueue.
REQ-010 SHALL have port busy  output  1  high in EXEC and DONE.
REQ-011 SHALL have port done  output  1  one-cycle pulse in DONE.
REQ-012 SHALL have port signal_underflow  output  1  one-cycle pulse in DONE for remove/peek on empty channel.
REQ-013 SHALL have port signal_overflow  output  1  one-cycle pulse in DONE for add on full channel.
REQ-014 SHALL have port addr_out  output  CH_W+ADDR_WIDTH  physical RAM address used by last add/remove/peek, {ch, pointer}.
REQ-015 SHALL have port data_out  output  DATA_WIDTH  entry read by last successful remove/peek.
REQ-016 SHALL have port count_out  output  ADDR_WIDTH+1  occupancy of last operated channel after the operation.
REQ-017 SHALL have ports empty_flags, full_flags  output  NUM_CH each  live per-channel status, bit i = channel i.

Function
REQ-018 SHALL store entries in one shared RAM of NUM_CH*DEPTH words x DATA_WIDTH; channel c occupies addresses c*DEPTH..c*DEPTH+DEPTH-1.
REQ-019 SHALL keep per channel: head (read ptr), tail (write ptr), both ADDR_WIDTH bits wrapping modulo DEPTH, and count 0..DEPTH.
REQ-020 SHALL run FSM IDLE -> EXEC -> DONE -> IDLE; IDLE->EXEC only when active=1; EXEC->DONE and DONE->IDLE unconditional.
REQ-021 SHALL latch cmd, ch_sel, data_in on the IDLE->EXEC edge; active in EXEC/DONE is ignored, not queued.
REQ-022 SHALL, for add with count<DEPTH, write data_in at {ch,tail} in EXEC, tail+=1, count+=1.
REQ-023 SHALL, for add with count==DEPTH, not write, not move pointers, pulse signal_overflow in DONE.
REQ-024 SHALL, for remove with count>0, read {ch,head} in EXEC, head+=1, count-=1; data_out valid from DONE until next successful read.
REQ-025 SHALL, for peek with count>0, read {ch,head} without changing head or count.
REQ-026 SHALL, for remove/peek with count==0, hold data_out and addr_out, pulse signal_underflow in DONE.
REQ-027 SHALL, for clear, set head=tail=count=0 of the selected channel only, no flags, addr_out/data_out held.
REQ-028 SHALL update addr_out and count_out on the EXEC->DONE edge; other channels' state never changes.
REQ-029 SHALL drive empty_flags[i]=(count_i==0), full_flags[i]=(count_i==DEPTH) from registered counts.
REQ-030 SHALL give a command latency of 2 cycles active-to-done and accept the next command on the cycle after done.

Reset
REQ-031 SHALL, on rst_n=0 at any time including mid-operation, force IDLE, all head/tail/count=0, busy/done/signal_*=0, addr_out=0, data_out=0, count_out=0, empty_flags all 1, full_flags all 0; the in-flight command is discarded.
REQ-032 SHALL leave RAM contents unreset; reads of never-written entries are not possible since count=0.

Verification
REQ-033 SHALL cover: add 0x15 to ch2, then remove ch2 -> data_out=0x15, addr_out=0x20, count_out=0, done 2 cycles after each strobe.
REQ-034 SHALL cover: 16 adds to ch1 (defaults) -> full_flags=0010, count_out=16; 17th add -> signal_overflow=1 one cycle, contents unchanged.
REQ-035 SHALL cover: remove on empty ch0 after reset -> signal_underflow=1, data_out=0, addr_out=0.
REQ-036 SHALL cover: wrap-around: fill ch3, remove 4, add 4 (values 0x3C..0x3F) -> addr_out of last add=0x33, subsequent 16 removes return FIFO order.
REQ-037 SHALL cover: peek twice on ch1 holding 0x0A -> both return 0x0A, count_out=1; clear ch1 -> empty_flags[1]=1, ch2 count unchanged.
REQ-038 SHALL cover: rst_n low during EXEC of an add -> busy=0 immediately, all counts 0, no done pulse.
